// File: rtl/iq_pkg.sv
// Shared issue-queue types: data/tag widths, operand slot and entry layouts, CDB bypass helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package iq_pkg;

  localparam int XLEN     = 32;
  localparam int TAG_W    = 6;
  localparam int IQ_DEPTH = 8;

  // One source operand: ready flag, producer tag, captured value.
  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } iq_opnd_t;

  // Full reservation entry; also used by the mult/div/mem queues.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic             imm;
    logic [XLEN-1:0]  imm_val;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    iq_opnd_t         rs1;
    iq_opnd_t         rs2;
    logic [TAG_W-1:0] rd_tag;
  } int_iq_entry_t;

  // Returns the operand with a matching CDB broadcast folded in, if it was still waiting.
  function automatic iq_opnd_t cdb_bypass(
    input iq_opnd_t          opnd,
    input logic              cdb_vld,
    input logic [TAG_W-1:0]  cdb_tag,
    input logic [XLEN-1:0]   cdb_dat
  );
    iq_opnd_t res;
    res = opnd;
    if (!opnd.rdy && cdb_vld && (opnd.tag == cdb_tag)) begin
      res.rdy = 1'b1;
      res.val = cdb_dat;
    end
    return res;
  endfunction

endpackage

// File: rtl/iq_operand_wakeup.sv
// One operand slot of an issue-queue entry: holds rdy/tag/val and snoops the CDB for its producer.
// Latency: capture lands at the clock edge of the broadcast; visible on o_rdy/o_val the next cycle.
// Backpressure: none; the slot always accepts a load or a broadcast.
// Ports: clk/rst_n; i_clr (flush), i_load + i_load_opnd (dispatch write, with same-cycle CDB bypass),
//        i_snoop_en (entry valid), i_cdb_vld/tag/dat (broadcast), o_rdy/o_val (slot state).
module iq_operand_wakeup
  import iq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  iq_opnd_t         i_load_opnd,
  input  logic             i_snoop_en,
  input  logic             i_cdb_vld,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [XLEN-1:0]  i_cdb_dat,
  output logic             o_rdy,
  output logic [XLEN-1:0]  o_val
);

  iq_opnd_t r_opnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd <= '0;
    end else if (i_clr) begin
      r_opnd <= '0;
    end else if (i_load) begin
      // A producer broadcasting in the dispatch cycle must not be missed.
      r_opnd <= cdb_bypass(i_load_opnd, i_cdb_vld, i_cdb_tag, i_cdb_dat);
    end else if (i_snoop_en) begin
      r_opnd <= cdb_bypass(r_opnd, i_cdb_vld, i_cdb_tag, i_cdb_dat);
    end
  end

  assign o_rdy = r_opnd.rdy;
  assign o_val = r_opnd.val;

endmodule

// File: rtl/int_issue_queue.sv
// In-order integer reservation FIFO with CDB wakeup; issues the head once its operands are ready.
// Latency: dispatch-to-issue 1 cycle minimum; a head woken at edge N presents iss_valid from cycle N+1.
// Backpressure: iss_valid/iss_ready handshake toward the ALU; registered queue_full stalls dispatch.
// Ports: clk/rst_n/flush; disp_* (dispatch push, disp_en qualifies); queue_full;
//        cdb_valid/tag/data (result broadcast); iss_valid/iss_ready and iss_* head payload.
module int_issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_en,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic             disp_imm,
  input  logic [XLEN-1:0]  disp_imm_val,
  input  logic [6:0]       disp_opcode,
  input  logic [2:0]       disp_funct3,
  input  logic [6:0]       disp_funct7,
  input  logic             disp_rs1_rdy,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic [XLEN-1:0]  disp_rs1_val,
  input  logic             disp_rs2_rdy,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic [XLEN-1:0]  disp_rs2_val,
  input  logic [TAG_W-1:0] disp_rd_tag,
  output logic             queue_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [XLEN-1:0]  iss_pc,
  output logic             iss_imm,
  output logic [XLEN-1:0]  iss_imm_val,
  output logic [6:0]       iss_opcode,
  output logic [2:0]       iss_funct3,
  output logic [6:0]       iss_funct7,
  output logic [XLEN-1:0]  iss_rs1_val,
  output logic [XLEN-1:0]  iss_rs2_val,
  output logic [TAG_W-1:0] iss_rd_tag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_full;

  logic             r_valid   [DEPTH];
  logic [XLEN-1:0]  r_pc      [DEPTH];
  logic             r_imm     [DEPTH];
  logic [XLEN-1:0]  r_imm_val [DEPTH];
  logic [6:0]       r_opcode  [DEPTH];
  logic [2:0]       r_funct3  [DEPTH];
  logic [6:0]       r_funct7  [DEPTH];
  logic [TAG_W-1:0] r_rd_tag  [DEPTH];

  logic             w_rs1_rdy [DEPTH];
  logic [XLEN-1:0]  w_rs1_val [DEPTH];
  logic             w_rs2_rdy [DEPTH];
  logic [XLEN-1:0]  w_rs2_val [DEPTH];

  int_iq_entry_t    w_disp;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  always_comb begin
    w_disp         = '0;
    w_disp.valid   = disp_en;
    w_disp.pc      = disp_pc;
    w_disp.imm     = disp_imm;
    w_disp.imm_val = disp_imm_val;
    w_disp.opcode  = disp_opcode;
    w_disp.funct3  = disp_funct3;
    w_disp.funct7  = disp_funct7;
    w_disp.rs1     = '{rdy: disp_rs1_rdy, tag: disp_rs1_tag, val: disp_rs1_val};
    w_disp.rs2     = '{rdy: disp_rs2_rdy, tag: disp_rs2_tag, val: disp_rs2_val};
    w_disp.rd_tag  = disp_rd_tag;
  end

  // Full is the registered flag, so a pop in the same cycle never admits a push.
  assign w_push      = w_disp.valid && !r_full;
  assign iss_valid   = (r_count != '0) && w_rs1_rdy[r_head] &&
                       (w_rs2_rdy[r_head] || r_imm[r_head]);
  assign w_pop       = iss_valid && iss_ready;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]   <= 1'b0;
        r_pc[i]      <= '0;
        r_imm[i]     <= 1'b0;
        r_imm_val[i] <= '0;
        r_opcode[i]  <= '0;
        r_funct3[i]  <= '0;
        r_funct7[i]  <= '0;
        r_rd_tag[i]  <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      // Head and tail only coincide when empty (no pop) or full (no push).
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_valid[r_tail]   <= 1'b1;
        r_pc[r_tail]      <= w_disp.pc;
        r_imm[r_tail]     <= w_disp.imm;
        r_imm_val[r_tail] <= w_disp.imm_val;
        r_opcode[r_tail]  <= w_disp.opcode;
        r_funct3[r_tail]  <= w_disp.funct3;
        r_funct7[r_tail]  <= w_disp.funct7;
        r_rd_tag[r_tail]  <= w_disp.rd_tag;
        r_tail            <= r_tail + PW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic w_load;
    assign w_load = w_push && (r_tail == PW'(g));

    iq_operand_wakeup u_rs1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (flush),
      .i_load      (w_load),
      .i_load_opnd (w_disp.rs1),
      .i_snoop_en  (r_valid[g]),
      .i_cdb_vld   (cdb_valid),
      .i_cdb_tag   (cdb_tag),
      .i_cdb_dat   (cdb_data),
      .o_rdy       (w_rs1_rdy[g]),
      .o_val       (w_rs1_val[g])
    );

    iq_operand_wakeup u_rs2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (flush),
      .i_load      (w_load),
      .i_load_opnd (w_disp.rs2),
      .i_snoop_en  (r_valid[g]),
      .i_cdb_vld   (cdb_valid),
      .i_cdb_tag   (cdb_tag),
      .i_cdb_dat   (cdb_data),
      .o_rdy       (w_rs2_rdy[g]),
      .o_val       (w_rs2_val[g])
    );
  end

  assign queue_full  = r_full;
  assign iss_pc      = r_pc[r_head];
  assign iss_imm     = r_imm[r_head];
  assign iss_imm_val = r_imm_val[r_head];
  assign iss_opcode  = r_opcode[r_head];
  assign iss_funct3  = r_funct3[r_head];
  assign iss_funct7  = r_funct7[r_head];
  assign iss_rs1_val = w_rs1_val[r_head];
  assign iss_rs2_val = w_rs2_val[r_head];
  assign iss_rd_tag  = r_rd_tag[r_head];

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed scenarios plus random traffic against a queue-based model.
// Expected issues are queued by the stimulus side; a monitor pops and compares on each handshake.
// Reset, wakeup, bypass, fill/wrap and flush scenarios run before the random phase.
module tb_int_issue_queue;
  import iq_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush, disp_en, disp_imm, disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0]      disp_pc, disp_imm_val, disp_rs1_val, disp_rs2_val;
  logic [6:0]       disp_opcode, disp_funct7;
  logic [2:0]       disp_funct3;
  logic [5:0]       disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
  logic             queue_full, cdb_valid, iss_valid, iss_ready, iss_imm;
  logic [5:0]       cdb_tag, iss_rd_tag;
  logic [31:0]      cdb_data, iss_pc, iss_imm_val, iss_rs1_val, iss_rs2_val;
  logic [6:0]       iss_opcode, iss_funct7;
  logic [2:0]       iss_funct3;

  int_issue_queue #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .disp_en(disp_en), .disp_pc(disp_pc),
    .disp_imm(disp_imm), .disp_imm_val(disp_imm_val), .disp_opcode(disp_opcode),
    .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_val(disp_rs1_val),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_val(disp_rs2_val),
    .disp_rd_tag(disp_rd_tag), .queue_full(queue_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_imm_val(iss_imm_val), .iss_opcode(iss_opcode), .iss_funct3(iss_funct3),
    .iss_funct7(iss_funct7), .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
    .iss_rd_tag(iss_rd_tag)
  );

  typedef struct {
    logic [31:0] pc;
    logic        imm;
    logic [31:0] imm_val;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        r1rdy;
    logic [5:0]  r1tag;
    logic [31:0] r1val;
    logic        r2rdy;
    logic [5:0]  r2tag;
    logic [31:0] r2val;
    logic [5:0]  rd;
  } m_ent_t;

  m_ent_t mq[$];     // model queue contents, oldest first
  m_ent_t exp_q[$];  // scoreboard: entries expected to issue, in order

  int total = 0;
  int bad   = 0;

  // Stimulus for the next cycle
  logic        s_flush = 1'b0, s_disp = 1'b0, s_cdb_v = 1'b0, s_rdy = 1'b0;
  logic [5:0]  s_cdb_tag = '0;
  logic [31:0] s_cdb_dat = '0;
  m_ent_t      s_ent;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic m_ent_t rand_ent();
    m_ent_t e;
    e.pc      = $urandom;
    e.imm     = ($urandom_range(0, 3) == 0);
    e.imm_val = $urandom;
    e.opc     = 7'($urandom);
    e.f3      = 3'($urandom);
    e.f7      = 7'($urandom);
    e.r1rdy   = ($urandom_range(0, 1) == 1);
    e.r1tag   = 6'($urandom_range(0, 7));
    e.r1val   = $urandom;
    e.r2rdy   = ($urandom_range(0, 1) == 1);
    e.r2tag   = 6'($urandom_range(0, 7));
    e.r2val   = $urandom;
    e.rd      = 6'($urandom);
    return e;
  endfunction

  function automatic m_ent_t ready_ent(logic [31:0] pc);
    m_ent_t e;
    e       = rand_ent();
    e.pc    = pc;
    e.r1rdy = 1'b1;
    e.r2rdy = 1'b1;
    return e;
  endfunction

  function automatic logic model_vld();
    return (mq.size() != 0) && mq[0].r1rdy && (mq[0].r2rdy || mq[0].imm);
  endfunction

  // Apply one clock edge's worth of the queue rules to the model.
  function automatic void model_step();
    logic   push, pop;
    m_ent_t e;
    if (s_flush) begin
      mq.delete();
      return;
    end
    push = s_disp && (mq.size() < D);
    pop  = model_vld() && s_rdy;
    foreach (mq[i]) begin
      if (s_cdb_v && !mq[i].r1rdy && mq[i].r1tag == s_cdb_tag) begin
        mq[i].r1rdy = 1'b1; mq[i].r1val = s_cdb_dat;
      end
      if (s_cdb_v && !mq[i].r2rdy && mq[i].r2tag == s_cdb_tag) begin
        mq[i].r2rdy = 1'b1; mq[i].r2val = s_cdb_dat;
      end
    end
    if (pop) exp_q.push_back(mq.pop_front());
    if (push) begin
      e = s_ent;
      if (s_cdb_v && !e.r1rdy && e.r1tag == s_cdb_tag) begin e.r1rdy = 1'b1; e.r1val = s_cdb_dat; end
      if (s_cdb_v && !e.r2rdy && e.r2tag == s_cdb_tag) begin e.r2rdy = 1'b1; e.r2val = s_cdb_dat; end
      mq.push_back(e);
    end
  endfunction

  task automatic drive_idle();
    flush = 1'b0; disp_en = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b0;
    disp_pc = '0; disp_imm = 1'b0; disp_imm_val = '0; disp_opcode = '0; disp_funct3 = '0;
    disp_funct7 = '0; disp_rs1_rdy = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
    disp_rs2_rdy = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0; disp_rd_tag = '0;
    cdb_tag = '0; cdb_data = '0;
  endtask

  // Check state after the last edge, drive the next cycle, advance the model.
  task automatic tick();
    @(negedge clk);
    chk("queue_full", 128'(queue_full), 128'(mq.size() == D));
    chk("iss_valid", 128'(iss_valid), 128'(model_vld()));
    flush        = s_flush;
    disp_en      = s_disp;
    disp_pc      = s_ent.pc;      disp_imm     = s_ent.imm;   disp_imm_val = s_ent.imm_val;
    disp_opcode  = s_ent.opc;     disp_funct3  = s_ent.f3;    disp_funct7  = s_ent.f7;
    disp_rs1_rdy = s_ent.r1rdy;   disp_rs1_tag = s_ent.r1tag; disp_rs1_val = s_ent.r1val;
    disp_rs2_rdy = s_ent.r2rdy;   disp_rs2_tag = s_ent.r2tag; disp_rs2_val = s_ent.r2val;
    disp_rd_tag  = s_ent.rd;
    cdb_valid    = s_cdb_v;  cdb_tag = s_cdb_tag;  cdb_data = s_cdb_dat;
    iss_ready    = s_rdy;
    model_step();
    s_flush = 1'b0; s_disp = 1'b0; s_cdb_v = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_iss_valid", 128'(iss_valid), 128'(0));
    chk("rst_queue_full", 128'(queue_full), 128'(0));
    mq.delete();
    exp_q.delete();
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every accepted issue against the scoreboard.
  initial begin
    m_ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && iss_valid === 1'b1 && iss_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got pc %0h expected no issue", iss_pc);
        end else begin
          e = exp_q.pop_front();
          chk("iss_pc", 128'(iss_pc), 128'(e.pc));
          chk("iss_payload",
              128'({iss_imm, iss_imm_val, iss_opcode, iss_funct3, iss_funct7, iss_rs1_val,
                    (e.imm ? 32'h0 : iss_rs2_val), iss_rd_tag}),
              128'({e.imm, e.imm_val, e.opc, e.f3, e.f7, e.r1val,
                    (e.imm ? 32'h0 : e.r2val), e.rd}));
        end
      end
    end
  end

  initial begin
    s_ent = ready_ent(32'h0);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("reset_iss_valid", 128'(iss_valid), 128'(0));
    chk("reset_queue_full", 128'(queue_full), 128'(0));
    chk("reset_iss_pc", 128'(iss_pc), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Both operands ready at dispatch
    s_ent = ready_ent(32'h100); s_disp = 1'b1; s_rdy = 1'b1;
    tick(); tick(); tick();

    // rs1 waits on tag 5, woken by a later broadcast
    s_ent = ready_ent(32'h200); s_ent.r1rdy = 1'b0; s_ent.r1tag = 6'd5; s_disp = 1'b1;
    tick(); tick(); tick();
    s_cdb_v = 1'b1; s_cdb_tag = 6'd5; s_cdb_dat = 32'hDEAD;
    tick(); tick(); tick();

    // rs2 captured by a broadcast in the dispatch cycle
    s_ent = ready_ent(32'h300); s_ent.imm = 1'b0; s_ent.r2rdy = 1'b0; s_ent.r2tag = 6'd3;
    s_disp = 1'b1; s_cdb_v = 1'b1; s_cdb_tag = 6'd3; s_cdb_dat = 32'h42;
    tick(); tick(); tick();

    // Fill, pop one, refill across the pointer wrap, then drain in order
    s_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      s_ent = ready_ent(32'h1000 + 32'(i)); s_disp = 1'b1; tick();
    end
    tick();
    s_rdy = 1'b1; tick();
    s_rdy = 1'b0; s_ent = ready_ent(32'h2000); s_disp = 1'b1; tick();
    tick();
    s_rdy = 1'b1;
    repeat (D + 2) tick();

    // Blocked head with ready younger entries, then flush
    s_rdy = 1'b0;
    s_ent = ready_ent(32'h3000); s_ent.r1rdy = 1'b0; s_ent.r1tag = 6'd40; s_disp = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      s_ent = ready_ent(32'h3100 + 32'(i)); s_disp = 1'b1; tick();
    end
    tick();
    s_flush = 1'b1; tick();
    s_rdy = 1'b1;
    repeat (4) tick();

    // Random traffic with an asynchronous reset in the middle
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      s_ent     = rand_ent();
      s_disp    = ($urandom_range(0, 2) != 0) && (mq.size() < D);
      s_cdb_v   = ($urandom_range(0, 1) == 1);
      s_cdb_tag = 6'($urandom_range(0, 7));
      s_cdb_dat = $urandom;
      s_rdy     = ($urandom_range(0, 3) != 0);
      s_flush   = ($urandom_range(0, 63) == 0);
      if (s_flush) s_rdy = 1'b0;
      tick();
    end

    // Drain: broadcast every tag until the model empties
    s_rdy = 1'b1;
    for (int k = 0; k < 300 && mq.size() != 0; k++) begin
      s_cdb_v = 1'b1; s_cdb_tag = 6'(k % 8); s_cdb_dat = $urandom;
      tick();
    end
    if (mq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", mq.size());
    end
    tick(); tick();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
